// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, error codes, mouse command bytes and
// small helpers used when sizing and framing a host-to-device transfer.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StData,
    StAck,
    StWaitIdle,
    StFinish
  } ps2_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_NO_ACK   = 2'b01;
  localparam logic [1:0] ERR_START_TO = 2'b10;
  localparam logic [1:0] ERR_XFER_TO  = 2'b11;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RATE   = 8'hF3;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a glitch-qualified falling-edge
// pulse on the clock and a both-lines-high idle flag.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ck_raw,
  input  logic dt_raw,
  output logic dt_sync,
  output logic fall,
  output logic idle
);

  // [0] metastability flop, [1] synced level, [3:2] history of the synced level
  logic [3:0] ck_sh;
  logic [1:0] dt_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_sh <= '1;
      dt_sh <= '1;
    end else begin
      ck_sh <= {ck_sh[2:0], ck_raw};
      dt_sh <= {dt_sh[0], dt_raw};
    end
  end

  assign dt_sync = dt_sh[1];
  // A fall only counts after the synced clock has been high for two cycles.
  assign fall    = ck_sh[3] & ck_sh[2] & ~ck_sh[1];
  assign idle    = ck_sh[1] & dt_sh[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, 8 data bits, odd
// parity and stop, then device ACK sampling. Drives open-drain enables only.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2ck_in,
  input  logic       ps2dt_in,
  output logic       ps2ck_oe,
  output logic       ps2dt_oe,
  output logic       tx_active,
  output logic       done,
  output logic [1:0] err
);

  // Timer also spans 20 ms at CLK_HZ, so any timeout retuned within the protocol never wraps.
  localparam int unsigned MaxWait = max_u(max_u(INHIBIT_CYCLES, START_TIMEOUT),
                                          max_u(XFER_TIMEOUT, CLK_HZ / 50));
  localparam int unsigned TimerW  = $clog2(MaxWait + 1);

  localparam logic [TimerW-1:0] InhibitLast = TimerW'(INHIBIT_CYCLES - 1);
  // Two early: the FINISH cycle makes done land exactly on the limit after the timer restart.
  localparam logic [TimerW-1:0] StartLast   = TimerW'(START_TIMEOUT - 2);
  localparam logic [TimerW-1:0] XferLast    = TimerW'(XFER_TIMEOUT - 2);

  ps2_state_e        state;
  logic [8:0]        shreg;
  logic [3:0]        bitcnt;
  logic [TimerW-1:0] timer;
  logic              idle_cnt;
  logic              dt_sync;
  logic              fall;
  logic              idle;

  ps2_line_sync u_line_sync (
    .clk     (CLOCK),
    .rst     (reset),
    .ck_raw  (ps2ck_in),
    .dt_raw  (ps2dt_in),
    .dt_sync (dt_sync),
    .fall    (fall),
    .idle    (idle)
  );

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      shreg     <= '0;
      bitcnt    <= '0;
      timer     <= '0;
      idle_cnt  <= 1'b0;
      ps2ck_oe  <= 1'b0;
      ps2dt_oe  <= 1'b0;
      cmd_ready <= 1'b1;
      tx_active <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_OK;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            shreg     <= {odd_parity(cmd_data), cmd_data};
            bitcnt    <= '0;
            timer     <= '0;
            err       <= ERR_OK;
            cmd_ready <= 1'b0;
            tx_active <= 1'b1;
            ps2ck_oe  <= 1'b1;
            state     <= StInhibit;
          end
        end
        StInhibit: begin
          if (timer == InhibitLast) begin
            ps2ck_oe <= 1'b0;
            ps2dt_oe <= 1'b1;
            timer    <= '0;
            state    <= StRts;
          end else begin
            timer <= timer + TimerW'(1);
          end
        end
        StRts: begin
          if (timer == StartLast) begin
            err      <= ERR_START_TO;
            ps2dt_oe <= 1'b0;
            state    <= StFinish;
          end else if (fall) begin
            ps2dt_oe <= ~shreg[0];
            bitcnt   <= 4'd1;
            timer    <= '0;
            state    <= StData;
          end else begin
            timer <= timer + TimerW'(1);
          end
        end
        StData, StAck, StWaitIdle: begin
          if (timer == XferLast) begin
            err      <= ERR_XFER_TO;
            ps2ck_oe <= 1'b0;
            ps2dt_oe <= 1'b0;
            state    <= StFinish;
          end else begin
            timer <= timer + TimerW'(1);
            if (state == StData && fall) begin
              if (bitcnt == 4'd9) begin
                ps2dt_oe <= 1'b0;
                state    <= StAck;
              end else begin
                ps2dt_oe <= ~shreg[bitcnt];
                bitcnt   <= bitcnt + 4'd1;
              end
            end else if (state == StAck && fall) begin
              err      <= dt_sync ? ERR_NO_ACK : ERR_OK;
              idle_cnt <= 1'b0;
              state    <= StWaitIdle;
            end else if (state == StWaitIdle) begin
              idle_cnt <= idle;
              if (idle && idle_cnt) begin
                state <= StFinish;
              end
            end
          end
        end
        StFinish: begin
          done      <= 1'b1;
          tx_active <= 1'b0;
          cmd_ready <= 1'b1;
          ps2ck_oe  <= 1'b0;
          ps2dt_oe  <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host, a scoreboard
// checks every done pulse against the expected frame and error code.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned Inhibit = 60;
  localparam int unsigned StartTo = 3000;
  localparam int unsigned XferTo  = 2000;
  localparam int          Half    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2ck_in;
  logic       ps2dt_in;
  logic       ps2ck_oe;
  logic       ps2dt_oe;
  logic       tx_active;
  logic       done;
  logic [1:0] err;

  // Device-side open-drain drivers; a wired-AND with the host enables.
  logic dev_ck;
  logic dev_dt;
  assign ps2ck_in = ~ps2ck_oe & dev_ck;
  assign ps2dt_in = ~ps2dt_oe & dev_dt;

  ps2_host_tx #(
    .INHIBIT_CYCLES (Inhibit),
    .START_TIMEOUT  (StartTo),
    .XFER_TIMEOUT   (XferTo)
  ) dut (
    .CLOCK     (clk),
    .reset     (reset),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ps2ck_in  (ps2ck_in),
    .ps2dt_in  (ps2dt_in),
    .ps2ck_oe  (ps2ck_oe),
    .ps2dt_oe  (ps2dt_oe),
    .tx_active (tx_active),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
    bit         frame;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [1:0] err;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[5];
  logic       cap_start;
  logic [7:0] cap_data;
  logic       cap_par;
  logic       cap_stop;
  int         first_fall_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse consumes the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done: got done with err %0h, expected none", err);
      end else begin
        e = sb.pop_front();
        check("done_err", err, e.err);
        check("done_ck_released", ps2ck_oe, 1'b0);
        check("done_dt_released", ps2dt_oe, 1'b0);
        check("done_tx_inactive", tx_active, 1'b0);
        if (e.frame) begin
          check("frame_start", cap_start, 1'b0);
          check("frame_data", cap_data, e.data);
          check("frame_parity", cap_par, ~^e.data);
          check("frame_stop", cap_stop, 1'b1);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit push, input logic [1:0] e, input bit frame);
    int   t = 0;
    exp_t x;
    if (push) begin
      x.data  = d;
      x.err   = e;
      x.frame = frame;
      sb.push_back(x);
    end
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = ~d;
    check("accept_tx_active", tx_active, 1'b1);
    check("accept_ready_low", cmd_ready, 1'b0);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (ps2ck_oe === 1'b1 && n < Inhibit + 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int bound, output int dc);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done !== 1'b1 && t < bound);
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles", bound);
    end
    dc = cyc;
  endtask

  // Device: waits for request-to-send, then issues nclk clock pulses, sampling host data
  // just before each rise and driving ACK low ahead of the 11th fall when ack is set.
  task automatic dev_frame(input int nclk, input bit ack);
    int t = 0;
    while (!(ps2ck_oe === 1'b0 && ps2dt_oe === 1'b1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      checks++;
      failures++;
      $display("FAIL dev_rts_wait: no request-to-send seen");
      return;
    end
    repeat (30) @(negedge clk);
    cap_start = ps2dt_in;
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11) begin
        dev_dt = ack ? 1'b0 : 1'b1;
        repeat (5) @(negedge clk);
      end
      if (i == 1) first_fall_cyc = cyc;
      dev_ck = 1'b0;
      repeat (Half) @(negedge clk);
      if (i <= 8) cap_data[i-1] = ps2dt_in;
      else if (i == 9) cap_par = ps2dt_in;
      else if (i == 10) cap_stop = ps2dt_in;
      dev_ck = 1'b1;
      if (i < nclk) repeat (Half) @(negedge clk);
    end
    dev_dt = 1'b1;
  endtask

  initial begin
    int n;
    int dc;
    int c0;
    int gap;
    logic ready_in_gap;
    checks    = 0;
    failures  = 0;
    dev_ck    = 1'b1;
    dev_dt    = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    reset     = 1'b1;

    vecs[0] = '{data: PS2_CMD_ENABLE, ack: 1'b1, err: ERR_OK};
    vecs[1] = '{data: PS2_CMD_RESET,  ack: 1'b0, err: ERR_NO_ACK};
    vecs[2] = '{data: 8'h00,          ack: 1'b1, err: ERR_OK};
    vecs[3] = '{data: 8'hA5,          ack: 1'b0, err: ERR_NO_ACK};
    vecs[4] = '{data: PS2_CMD_RATE,   ack: 1'b1, err: ERR_OK};

    repeat (3) @(negedge clk);
    check("rst_ck_oe", ps2ck_oe, 1'b0);
    check("rst_dt_oe", ps2dt_oe, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_tx_active", tx_active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 2'b00);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, 1'b1, vecs[i].err, 1'b1);
      wait_release(n);
      check($sformatf("v%0d_inhibit_len", i), n, Inhibit);
      check($sformatf("v%0d_rts_dt_oe", i), ps2dt_oe, 1'b1);
      dev_frame(11, vecs[i].ack);
      wait_done(XferTo, dc);
      check($sformatf("v%0d_ready_with_done", i), cmd_ready, 1'b1);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_err_held", i), err, vecs[i].err);
      check($sformatf("v%0d_done_single", i), done, 1'b0);
    end

    // Device never clocks: done lands exactly StartTo cycles after ck release.
    send(PS2_CMD_RATE, 1'b1, ERR_START_TO, 1'b0);
    wait_release(n);
    c0 = cyc;
    wait_done(StartTo + 50, dc);
    check("start_to_latency", dc - c0, StartTo);

    // Device stops after 4 clocks: 2 sync flops + detect cycle precede the timer restart.
    send(8'h5A, 1'b1, ERR_XFER_TO, 1'b0);
    wait_release(n);
    dev_frame(4, 1'b1);
    wait_done(XferTo + 50, dc);
    check("xfer_to_latency", dc - first_fall_cyc, XferTo + 3);

    // Reset mid-DATA with bit 4 = 0 so the host is actively pulling data low.
    send(8'hE0, 1'b0, ERR_OK, 1'b0);
    dev_frame(5, 1'b1);
    check("pre_reset_dt_oe", ps2dt_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_dt_oe", ps2dt_oe, 1'b0);
    check("async_rst_ck_oe", ps2ck_oe, 1'b0);
    check("async_rst_tx_active", tx_active, 1'b0);
    check("async_rst_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(PS2_CMD_ENABLE, 1'b1, ERR_OK, 1'b1);
    dev_frame(11, 1'b1);
    wait_done(XferTo, dc);

    // cmd_valid held with a changed byte: first byte framed, second accepted right after FINISH.
    sb.push_back('{data: 8'h3C, err: ERR_OK, frame: 1'b1});
    sb.push_back('{data: 8'hC3, err: ERR_OK, frame: 1'b1});
    cmd_data  = 8'h3C;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_data = 8'hC3;
    check("hold_first_accepted", tx_active, 1'b1);
    dev_frame(11, 1'b1);
    n = 0;
    while (tx_active !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    gap = 0;
    ready_in_gap = cmd_ready;
    while (tx_active === 1'b0 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("hold_ready_in_gap", ready_in_gap, 1'b1);
    check("hold_tx_gap", gap, 1);
    dev_frame(11, 1'b1);
    wait_done(XferTo, dc);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
